// File: rtl/div_seq_pkg.sv
// Shared CPU package: divider FSM state encoding, iteration count and the
// Hi/Lo source-mux select codes. The control unit and the divider both import
// this package, so they agree on which mux input carries the divider result.
package div_seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } div_state_e;

   localparam int DIV_ITER = 32;

   // Hi/Lo source mux selects
   localparam logic [1:0] HILO_SEL_ALU = 2'd0;
   localparam logic [1:0] HILO_SEL_MUL = 2'd1;
   localparam logic [1:0] HILO_SEL_DIV = 2'd2;
   localparam logic [1:0] HILO_SEL_MT  = 2'd3;

endpackage

// File: rtl/div_seq_abs_neg.sv
// abs_neg: conditional two's-complement negation.
// Used for operand absolute value (neg = operand sign bit) and for applying
// the quotient/remainder sign after the unsigned iteration.
// Ports:
//   in_val  in  W  value to pass through or negate
//   neg     in  1  1 = output -in_val (mod 2^W)
//   out_val out W  result
module abs_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] in_val,
   input  logic         neg,
   output logic [W-1:0] out_val
);

   assign out_val = neg ? (~in_val + {{(W-1){1'b0}}, 1'b1}) : in_val;

endmodule

// File: rtl/div_seq.sv
// div_seq: sequential signed divider (restoring, one quotient bit per clock).
// Quotient truncates toward zero, remainder carries the dividend's sign.
// Results go to the Hi (remainder) / Lo (quotient) source muxes.
//
// Optional feature macro: DIV_BY_ZERO_EXC_EN
//   defined   - divisor 0 skips the iteration, pulses done with div_zero = 1,
//               hi_out/lo_out keep their previous values.
//   undefined - div_zero is always 0; divisor 0 runs the normal algorithm.
//
// Ports:
//   clk       in   1       system clock, rising edge
//   reset     in   1       asynchronous reset, active low
//   start     in   1       request pulse, only honoured in IDLE
//   dividend  in   DATA_W  signed dividend
//   divisor   in   DATA_W  signed divisor
//   busy      out  1       operation in progress (through the DONE cycle)
//   done      out  1       one-cycle completion pulse
//   div_zero  out  1       divide-by-zero flag, valid with done
//   hi_out    out  DATA_W  remainder
//   lo_out    out  DATA_W  quotient
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one restoring-division step per clock, DATA_W steps
// FIX   | apply quotient/remainder signs, register hi_out/lo_out
// DONE  | done pulse for one cycle, then back to IDLE
module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_W = DIV_ITER
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

   div_state_e        state_q, state_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              q_sign_q, q_sign_d;
   logic              r_sign_q, r_sign_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              div_zero_q, div_zero_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic [DATA_W-1:0] a_abs, b_abs, quo_fix, rem_fix;
   logic [DATA_W:0]   shifted, trial;
   logic              zero_req;

   abs_neg #(.W(DATA_W)) u_abs_a (.in_val(dividend), .neg(dividend[DATA_W-1]), .out_val(a_abs));
   abs_neg #(.W(DATA_W)) u_abs_b (.in_val(divisor),  .neg(divisor[DATA_W-1]),  .out_val(b_abs));
   abs_neg #(.W(DATA_W)) u_fix_q (.in_val(quo_q),    .neg(q_sign_q),           .out_val(quo_fix));
   abs_neg #(.W(DATA_W)) u_fix_r (.in_val(rem_q),    .neg(r_sign_q),           .out_val(rem_fix));

   // Partial remainder is DATA_W+1 bits wide so the trial subtraction's borrow
   // lands in the MSB.
   assign shifted = {rem_q, quo_q[DATA_W-1]};
   assign trial   = shifted - {1'b0, dvs_q};

`ifdef DIV_BY_ZERO_EXC_EN
   assign zero_req = (divisor == '0);
`else
   assign zero_req = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      cnt_d      = cnt_q;
      q_sign_d   = q_sign_q;
      r_sign_d   = r_sign_q;
      busy_d     = busy_q;
      done_d     = done_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      case (state_q)
         IDLE: begin
            if (start && zero_req) begin
               state_d    = DONE;
               busy_d     = 1'b1;
               done_d     = 1'b1;
               div_zero_d = 1'b1;
            end else if (start) begin
               state_d  = RUN;
               busy_d   = 1'b1;
               quo_d    = a_abs;
               dvs_d    = b_abs;
               rem_d    = '0;
               cnt_d    = CNT_LOAD;
               q_sign_d = dividend[DATA_W-1] ^ divisor[DATA_W-1];
               r_sign_d = dividend[DATA_W-1];
            end
         end
         RUN: begin
            if (!trial[DATA_W]) begin
               rem_d = trial[DATA_W-1:0];
               quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
               rem_d = shifted[DATA_W-1:0];
               quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            hi_d    = rem_fix;
            lo_d    = quo_fix;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            div_zero_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         cnt_q      <= '0;
         q_sign_q   <= 1'b0;
         r_sign_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         cnt_q      <= cnt_d;
         q_sign_q   <= q_sign_d;
         r_sign_q   <= r_sign_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;

endmodule
